// File: rtl/enemy_sprite_renderer_pkg.sv
// Shared geometry constants and sprite ROM layout for the enemy fleet renderer.
// Latency: n/a (constants and a pure lookup function).
// Backpressure: n/a.
package enemy_sprite_renderer_pkg;

    // Fleet cell pitch in pixels (square cells).
    localparam int CELL_PITCH   = 32;
    // Each ROM bit is drawn as a SPRITE_SCALE x SPRITE_SCALE block.
    localparam int SPRITE_SCALE = 2;
    // Sprite height in ROM rows; also the ROM address stride between animation phases.
    localparam int SPRITE_H     = 8;
    // Pixels per ROM row; bit ROM_BITS-1 is the leftmost pixel.
    localparam int ROM_BITS     = 8;

    // Per-grid-row sprite base address, eight 8-bit entries, entry 0 in the low byte.
    // Row 0 uses the top enemy type, rows 1..2 the middle type, all others the bottom type.
    localparam logic [63:0] SPRITE_BASE_TBL = {
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd16, 8'd16, 8'd32
    };

    // Sprite base ROM address for a fleet grid row.
    function automatic logic [7:0] sprite_base(input logic [2:0] row);
        return SPRITE_BASE_TBL[{row, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/enemy_anim_timer.sv
// Counts video frames and flips the enemy animation phase every ANIM_PERIOD frames.
// Latency: anim_frame changes on the clock edge that samples the terminal frame_start.
// Backpressure: none; frame_start is a free-running pulse and is never stalled.
module enemy_anim_timer #(
    parameter int ANIM_PERIOD = 30
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_start,
    output logic anim_frame
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       anim_q;
    logic       anim_d;

    // Next frame count and phase: wrap and toggle on the terminal frame.
    always_comb begin
        cnt_d  = cnt_q;
        anim_d = anim_q;
        if (frame_start) begin
            if (cnt_q == 8'(ANIM_PERIOD - 1)) begin
                cnt_d  = 8'd0;
                anim_d = ~anim_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Counter and phase registers; reset wins over a coincident frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= 8'd0;
            anim_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            anim_q <= anim_d;
        end
    end

    assign anim_frame = anim_q;

endmodule

// File: rtl/enemy_sprite_renderer.sv
// Decides per scan pixel whether an alive enemy sprite covers it, using an external sprite ROM.
// Latency: 2 cycles from DrawX/DrawY to pixel_on/pixel_row/pixel_col; rom_addr after 1 cycle.
// Backpressure: none; accepts one pixel every cycle and never stalls.
module enemy_sprite_renderer
    import enemy_sprite_renderer_pkg::*;
#(
    parameter int COLS        = 11,
    parameter int ROWS        = 5,
    parameter int ANIM_PERIOD = 30
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           fleet_x,
    input  logic [9:0]           fleet_y,
    input  logic [ROWS*COLS-1:0] alive,
    output logic [7:0]           rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 pixel_on,
    output logic [2:0]           pixel_row,
    output logic [3:0]           pixel_col,
    output logic                 anim_frame
);

    localparam int NCELL     = ROWS * COLS;
    localparam int IDX_W     = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int GRID_W    = COLS * CELL_PITCH;
    localparam int GRID_H    = ROWS * CELL_PITCH;
    localparam int SPRITE_PX = SPRITE_H * SPRITE_SCALE;

    // Frame-latched fleet state; only frame_start may change what a frame shows.
    logic [9:0]       fleet_x_q, fleet_x_d;
    logic [9:0]       fleet_y_q, fleet_y_d;
    logic [NCELL-1:0] alive_q,   alive_d;

    // Stage 1: hit test and ROM address.
    logic [7:0]       rom_addr_q, rom_addr_d;
    logic             s1_vld_q,   s1_vld_d;
    logic [2:0]       s1_bit_q,   s1_bit_d;
    logic [2:0]       s1_row_q,   s1_row_d;
    logic [3:0]       s1_col_q,   s1_col_d;

    // Stage 2: lit pixel and its grid position.
    logic             pixel_on_q,  pixel_on_d;
    logic [2:0]       pixel_row_q, pixel_row_d;
    logic [3:0]       pixel_col_q, pixel_col_d;

    // Stage 1 decode of the incoming coordinate.
    logic [10:0]      dx;
    logic [10:0]      dy;
    logic             hit;
    logic [3:0]       cell_col;
    logic [2:0]       cell_row;
    logic [4:0]       lx;
    logic [4:0]       ly;
    logic             in_sprite;
    logic [IDX_W-1:0] cell_idx;
    logic             cell_alive;

    enemy_anim_timer #(
        .ANIM_PERIOD (ANIM_PERIOD)
    ) u_anim_timer (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .anim_frame  (anim_frame)
    );

    // Capture fleet position and alive mask once per frame.
    always_comb begin
        fleet_x_d = fleet_x_q;
        fleet_y_d = fleet_y_q;
        alive_d   = alive_q;
        if (frame_start) begin
            fleet_x_d = fleet_x;
            fleet_y_d = fleet_y;
            alive_d   = alive;
        end
    end

    // Grid-relative offset, cell decode and sprite address for the current pixel.
    // The subtraction is done at 11 bits so a pixel left of/above the fleet shows
    // up as a set sign bit rather than wrapping into the grid.
    always_comb begin
        dx         = {1'b0, DrawX} - {1'b0, fleet_x_q};
        dy         = {1'b0, DrawY} - {1'b0, fleet_y_q};
        hit        = !dx[10] && (dx < 11'(GRID_W)) && !dy[10] && (dy < 11'(GRID_H));
        cell_col   = dx[8:5];
        cell_row   = dy[7:5];
        lx         = dx[4:0];
        ly         = dy[4:0];
        in_sprite  = (lx < 5'(SPRITE_PX)) && (ly < 5'(SPRITE_PX));
        cell_idx   = IDX_W'(int'(cell_row) * COLS + int'(cell_col));
        // Out-of-grid cells may index past the mask; hit masks that case off.
        cell_alive = hit && alive_q[cell_idx];

        rom_addr_d = sprite_base(cell_row)
                   + (anim_frame ? 8'(SPRITE_H) : 8'd0)
                   + {5'd0, ly[3:1]};
        s1_vld_d   = hit && in_sprite && cell_alive;
        s1_bit_d   = lx[3:1];
        s1_row_d   = cell_row;
        s1_col_d   = cell_col;
    end

    // ROM data returns in the same cycle as rom_addr_q; pick the scaled bit.
    always_comb begin
        pixel_on_d  = s1_vld_q && rom_data[3'(ROM_BITS - 1) - s1_bit_q];
        pixel_row_d = 3'd0;
        pixel_col_d = 4'd0;
        if (pixel_on_d) begin
            pixel_row_d = s1_row_q;
            pixel_col_d = s1_col_q;
        end
    end

    // Frame latch and both pipeline stages; reset clears everything including the mask.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fleet_x_q   <= 10'd0;
            fleet_y_q   <= 10'd0;
            alive_q     <= '0;
            rom_addr_q  <= 8'd0;
            s1_vld_q    <= 1'b0;
            s1_bit_q    <= 3'd0;
            s1_row_q    <= 3'd0;
            s1_col_q    <= 4'd0;
            pixel_on_q  <= 1'b0;
            pixel_row_q <= 3'd0;
            pixel_col_q <= 4'd0;
        end else begin
            fleet_x_q   <= fleet_x_d;
            fleet_y_q   <= fleet_y_d;
            alive_q     <= alive_d;
            rom_addr_q  <= rom_addr_d;
            s1_vld_q    <= s1_vld_d;
            s1_bit_q    <= s1_bit_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            pixel_on_q  <= pixel_on_d;
            pixel_row_q <= pixel_row_d;
            pixel_col_q <= pixel_col_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pixel_on  = pixel_on_q;
    assign pixel_row = pixel_row_q;
    assign pixel_col = pixel_col_q;

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// Directed bench for enemy_sprite_renderer with a small behavioural sprite ROM.
// Latency: checks rom_addr one cycle and pixel outputs two cycles after a coordinate.
// Backpressure: n/a.
module tb_enemy_sprite_renderer;

    localparam int COLS = 11;
    localparam int ROWS = 5;
    localparam logic [ROWS*COLS-1:0] ALL_ALIVE = '1;

    logic                 Clk;
    logic                 Reset;
    logic                 frame_start;
    logic [9:0]           DrawX;
    logic [9:0]           DrawY;
    logic [9:0]           fleet_x;
    logic [9:0]           fleet_y;
    logic [ROWS*COLS-1:0] alive;
    logic [7:0]           rom_addr;
    logic [7:0]           rom_data;
    logic                 pixel_on;
    logic [2:0]           pixel_row;
    logic [3:0]           pixel_col;
    logic                 anim_frame;

    int n_checks = 0;
    int n_errors = 0;

    enemy_sprite_renderer #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .ANIM_PERIOD (3)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .fleet_x     (fleet_x),
        .fleet_y     (fleet_y),
        .alive       (alive),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_on    (pixel_on),
        .pixel_row   (pixel_row),
        .pixel_col   (pixel_col),
        .anim_frame  (anim_frame)
    );

    // Sprite ROM: address 7 is blank, every other row has its two edge bits dark.
    always_comb begin
        rom_data = (rom_addr == 8'd7) ? 8'h00 : 8'h7E;
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one coordinate, check rom_addr after one cycle (skipped when exp_addr < 0)
    // and the pixel outputs after two.
    task automatic probe(input string tag, input int x, input int y, input int exp_addr,
                         input int exp_on, input int exp_row, input int exp_col);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
        if (exp_addr >= 0) chk({tag, ".addr"}, rom_addr, exp_addr);
        @(negedge Clk);
        chk({tag, ".on"},  pixel_on,  exp_on);
        chk({tag, ".row"}, pixel_row, exp_row);
        chk({tag, ".col"}, pixel_col, exp_col);
    endtask

    task automatic pulse(input int fx, input int fy, input logic [ROWS*COLS-1:0] alv);
        @(negedge Clk);
        fleet_x     = 10'(fx);
        fleet_y     = 10'(fy);
        alive       = alv;
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    // Stream a w x h rectangle one pixel per cycle and count lit outputs.
    task automatic stream_count(input int x0, input int y0, input int w, input int h,
                                output int cnt);
        int n;
        n   = w * h;
        cnt = 0;
        for (int k = 0; k < n + 2; k++) begin
            @(negedge Clk);
            if (k >= 2) cnt += int'(pixel_on);
            if (k < n) begin
                DrawX = 10'(x0 + k % w);
                DrawY = 10'(y0 + k / w);
            end
        end
    endtask

    initial begin
        int cnt;
        logic [ROWS*COLS-1:0] dead12;

        // Reset together with frame_start: reset wins, nothing is latched.
        Reset       = 1'b1;
        frame_start = 1'b1;
        fleet_x     = 10'd100;
        fleet_y     = 10'd50;
        alive       = ALL_ALIVE;
        DrawX       = 10'd102;
        DrawY       = 10'd50;
        @(negedge Clk);
        chk("rst.pixel_on", pixel_on, 0);
        chk("rst.anim", anim_frame, 0);
        chk("rst.rom_addr", rom_addr, 0);
        Reset       = 1'b0;
        frame_start = 1'b0;
        probe("rst.alive_clear", 2, 0, -1, 0, 0, 0);

        // Frame 1: fleet at (100,50), all alive, phase 0.
        pulse(100, 50, ALL_ALIVE);
        chk("f1.anim", anim_frame, 0);
        probe("f1.first", 102, 50, 32, 1, 0, 0);
        probe("f1.last_blank", 100 + 335, 50 + 143, 7, 0, 0, 0);
        probe("f1.miss_right", 452, 50, -1, 0, 0, 0);
        probe("f1.miss_left", 99, 50, -1, 0, 0, 0);
        probe("f1.right_col", 432, 50, 32, 1, 0, 10);
        probe("f1.last_cell", 432, 190, 6, 1, 4, 10);
        probe("f1.edge_bit", 100, 50, 32, 0, 0, 0);
        probe("f1.row1", 134, 84, 17, 1, 1, 1);
        probe("f1.row3", 102, 146, 0, 1, 3, 0);
        probe("f1.row2", 102, 128, 23, 1, 2, 0);
        stream_count(100, 50, 18, 1, cnt);
        chk("f1.line_lit", cnt, 12);

        // Frame 2: cell (row 1, col 1) destroyed.
        dead12     = ALL_ALIVE;
        dead12[12] = 1'b0;
        pulse(100, 50, dead12);
        stream_count(132, 82, 16, 16, cnt);
        chk("f2.dead_cell_lit", cnt, 0);
        probe("f2.right_nb", 166, 84, 17, 1, 1, 2);
        probe("f2.left_nb", 102, 84, 17, 1, 1, 0);
        probe("f2.below_nb", 134, 116, 17, 1, 2, 1);

        // Frame 3 toggles the phase; the coincident pixel still sees phase 0.
        @(negedge Clk);
        fleet_x     = 10'd100;
        fleet_y     = 10'd50;
        alive       = ALL_ALIVE;
        DrawX       = 10'd102;
        DrawY       = 10'd146;
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        chk("f3.anim", anim_frame, 1);
        chk("f3.addr_old_phase", rom_addr, 0);
        @(negedge Clk);
        chk("f3.addr_new_phase", rom_addr, 8);
        probe("f3.row3", 102, 146, 8, 1, 3, 0);

        // Input fleet_x moves mid-frame without a pulse: no visible effect.
        fleet_x = 10'd300;
        probe("f3.moved_input", 102, 146, 8, 1, 3, 0);
        stream_count(100, 50, 18, 1, cnt);
        chk("f3.line_lit", cnt, 12);

        pulse(100, 50, ALL_ALIVE);
        pulse(100, 50, ALL_ALIVE);
        chk("f5.anim", anim_frame, 1);

        // Frame 6: phase back to 0 and fleet jumps to 630; coincident pixel uses old state.
        @(negedge Clk);
        fleet_x     = 10'd630;
        fleet_y     = 10'd50;
        alive       = ALL_ALIVE;
        DrawX       = 10'd102;
        DrawY       = 10'd146;
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        chk("f6.anim", anim_frame, 0);
        chk("f6.addr_old", rom_addr, 8);
        @(negedge Clk);
        chk("f6.pix_old_fleet", pixel_on, 1);
        @(negedge Clk);
        chk("f6.pix_new_fleet", pixel_on, 0);
        probe("f6.wrap_miss", 5, 50, -1, 0, 0, 0);
        probe("f6.near_edge", 632, 50, 32, 1, 0, 0);
        probe("f6.screen_edge", 639, 57, 35, 1, 0, 0);

        // Mid-frame reset clears the pipeline and the latched mask.
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("mrst.anim", anim_frame, 0);
        chk("mrst.pixel_on", pixel_on, 0);
        chk("mrst.rom_addr", rom_addr, 0);
        probe("mrst.dark", 2, 0, -1, 0, 0, 0);
        pulse(0, 0, ALL_ALIVE);
        probe("mrst.relit", 2, 0, 32, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enemy_sprite_renderer.md
ENEMY_SPRITE_RENDERER -- requirements
Module: enemy_sprite_renderer

Interface
REQ-001 Parameter: COLS, default 11, enemy columns in the fleet grid.
REQ-002 Parameter: ROWS, default 5, enemy rows in the fleet grid.
REQ-003 Parameter: ANIM_PERIOD, default 30, frames per animation toggle, legal range 1..255.
REQ-004 Port: Clk  input  1  single system clock; all state on its rising edge.
REQ-005 Port: Reset  input  1  synchronous, active-high reset.
REQ-006 Port: frame_start  input  1  one-cycle pulse at the start of each video frame.
REQ-007 Port: DrawX  input  10  current pixel column, 0..639.
REQ-008 Port: DrawY  input  10  current pixel row, 0..479.
REQ-009 Port: fleet_x  input  10  fleet grid top-left X; sampled only on frame_start.
REQ-010 Port: fleet_y  input  10  fleet grid top-left Y; sampled only on frame_start.
REQ-011 Port: alive  input  ROWS*COLS  alive mask, bit index = row*COLS+col; sampled only on frame_start.
REQ-012 Port: rom_addr  output  8  address to sprite ROM (combinational ROM, data valid same cycle).
REQ-013 Port: rom_data  input  8  ROM row bits; bit 7 = leftmost pixel.
REQ-014 Port: pixel_on  output  1  enemy pixel is lit at the delayed coordinate.
REQ-015 Port: pixel_row  output  3  grid row of the lit pixel; 0 when pixel_on=0.
REQ-016 Port: pixel_col  output  4  grid column of the lit pixel; 0 when pixel_on=0.
REQ-017 Port: anim_frame  output  1  current animation phase.

Function
REQ-018 Geometry: cell pitch 32x32 px; sprite is 8x8 ROM bits scaled 2x to 16x16 at cell-local (0..15, 0..15); cell-local 16..31 is blank.
REQ-019 Hit test: dx = DrawX - fleet_x_q, dy = DrawY - fleet_y_q computed at 11 bits signed; hit only when 0 <= dx < COLS*32 and 0 <= dy < ROWS*32.
REQ-020 Cell: col = dx[8:5], row = dy[7:5], lx = dx[4:0], ly = dy[4:0]; no dividers.
REQ-021 Sprite base: row 0 -> 32, rows 1..2 -> 16, rows 3..ROWS-1 -> 0.
REQ-022 rom_addr = base + 8*anim_frame + ly[3:1], registered in stage 1; max value 47.
REQ-023 Stage 1 also registers: valid = hit & lx<16 & ly<16 & alive_q[row*COLS+col], bit index lx[3:1], row, col.
REQ-024 Stage 2 registers pixel_on = valid & rom_data[7 - bitidx], plus pixel_row/pixel_col (zeroed when not lit).
REQ-025 Latency: pixel outputs correspond to DrawX/DrawY presented 2 cycles earlier; one pixel per cycle, no stalls.
REQ-026 Frame latch: on frame_start, fleet_x_q, fleet_y_q, alive_q load from inputs; changes between pulses have no effect on the frame.
REQ-027 Animation: frame counter increments on each frame_start; when counter = ANIM_PERIOD-1 and frame_start, counter clears and anim_frame toggles in the same cycle.
REQ-028 anim_frame change takes effect on rom_addr from the cycle after the toggle.
REQ-029 frame_start coincident with a pixel: that pixel uses the pre-latch fleet/alive values.
REQ-030 Edge pixels: dx = COLS*32-1 is in range; dx = COLS*32 or negative dx is a miss, including fleet_x near 639 where DrawX wraps only via negative dx.

Reset
REQ-031 Reset, on the clock edge, clears: pipeline valid bits, pixel_on, pixel_row, pixel_col, rom_addr, frame counter, anim_frame, fleet_x_q, fleet_y_q, alive_q.
REQ-032 Reset has priority over frame_start in the same cycle.
REQ-033 After reset mid-frame, nothing renders (alive_q=0) until the next frame_start.

Structure
REQ-034 Shared package holds: cell pitch (32), sprite scale (2), sprite height (8), per-row sprite base table, ROM bits-per-row.
REQ-035 One sub-module: enemy_anim_timer (frame counter + anim_frame toggle).
REQ-036 sprite_rom instantiated outside; this block only drives rom_addr and consumes rom_data.

Verification
REQ-037 Reset asserted with frame_start=1 -> pixel_on=0, anim_frame=0, rom_addr=0 next cycle; alive_q stays 0.
REQ-038 fleet=(100,50), alive all 1, anim 0, DrawX/DrawY=(102,50) -> rom_addr=32 after 1 cycle; pixel_on=1 (ROM row 32 bit 6 lit) after 2 cycles, pixel_row=0, pixel_col=0.
REQ-039 Same fleet, pixel (100+32*10+15, 50+32*4+15) -> rom_addr=7, pixel_on=0 (ROM row 7 blank); pixel (100+352, 50) -> miss.
REQ-040 Clear alive bit 12 (row 1, col 1), frame_start, scan cell (132..147, 82..97) -> pixel_on=0 throughout; neighbouring cells still lit.
REQ-041 ANIM_PERIOD=3, 6 frame_start pulses -> anim_frame toggles after pulses 3 and 6; rom_addr for row 3 cell top line moves 0 -> 8 -> 0.
REQ-042 Change fleet_x mid-frame without frame_start -> output identical to unchanged run; next frame_start applies new position.
